// File: rtl/wb_pkg.sv
// Shared definitions for the write-back commit buffer: RISC-V opcode
// encodings, the ebreak instruction word, the write-back source enum and
// the per-entry control struct.
// Build option: define WB_TRACE_EN to keep full trace fields per entry.
package wb_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [31:0] EBREAK = 32'h00100073;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_MEM  = 2'd2,
        WB_SRC_PC   = 2'd3
    } wb_src_e;

    // Control bits kept per buffered entry; data-path fields live in
    // separately parameterised arrays in the top.
    typedef struct packed {
        logic wen;
        logic is_ebreak;
    } wb_ctrl_t;

    // Which value an instruction writes back, decided from its opcode alone.
    function automatic wb_src_e wb_select(input logic [6:0] opcode);
        wb_src_e src;
        case (opcode)
            LOAD:                   src = WB_SRC_MEM;
            JAL, JALR:              src = WB_SRC_PC;
            LUI, AUIPC, OP, OP_IMM: src = WB_SRC_ALU;
            default:                src = WB_SRC_NONE;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match forwarding search over the commit buffer. Entries are
// scanned oldest to youngest starting at the head, so the last match seen
// is the youngest one. Register x0 never forwards.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int RD_W  = 5
) (
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0]         wen,
    input  logic [RD_W-1:0]          rd_arr   [DEPTH],
    input  logic [XLEN-1:0]          data_arr [DEPTH],
    input  logic [RD_W-1:0]          fwd_rs,
    output logic                     fwd_hit,
    output logic [XLEN-1:0]          fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Age-ordered scan; a younger match overrides an older one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (fwd_rs != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head + PTR_W'(k);
                if (valid[idx] && wen[idx] && (rd_arr[idx] == fwd_rs)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_arr[idx];
                end
            end
        end
    end

endmodule

// File: rtl/wb_commit_buffer.sv
// Write-back stage with a DEPTH-entry in-order commit buffer feeding a
// single, stallable register-file write port. Provides youngest-match
// forwarding over buffered results and halts after an ebreak retires.
// Build option: WB_TRACE_EN keeps and drives the per-entry trace fields;
// without it the trace outputs are tied to zero.
//
// Handshakes: an instruction transfers when m_to_w_valid && w_allow_in at a
// rising clk edge; w_allow_in depends only on registered state. A head entry
// retires (W_commit) when it is valid, the stage is not halted and either
// rf_wr_ready is high or the entry does not write the register file.
module wb_commit_buffer
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int RD_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_to_w_valid,
    output logic                     w_allow_in,
    input  logic [6:0]               M_opcode,
    input  logic [RD_W-1:0]          M_rd,
    input  logic [XLEN-1:0]          M_valE,
    input  logic [XLEN-1:0]          m_valM,
    input  logic [XLEN-1:0]          M_default_pc,
    input  logic [XLEN-1:0]          M_cur_pc,
    input  logic [XLEN-1:0]          M_instr,
    input  logic [XLEN-1:0]          M_pred_pc,
    input  logic [XLEN-1:0]          M_predicted_pc,
    input  logic                     rf_wr_ready,
    output logic                     rf_we,
    output logic [RD_W-1:0]          rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     w_valid,
    output logic                     W_commit,
    output logic [XLEN-1:0]          W_cur_pc,
    output logic [XLEN-1:0]          W_instr,
    output logic [XLEN-1:0]          W_pred_pc,
    output logic [XLEN-1:0]          W_predicted_pc,
    input  logic [RD_W-1:0]          fwd_rs,
    output logic                     fwd_hit,
    output logic [XLEN-1:0]          fwd_data,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             halted_q;

    wb_ctrl_t         ctrl_q [DEPTH];
    logic [RD_W-1:0]  rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];

    wb_src_e          src;
    logic [XLEN-1:0]  sel_data;
    logic             sel_wen;
    logic             full, empty, enq, retire;
    logic [DEPTH-1:0] valid_mask, wen_mask;
    logic [PTR_W-1:0] off;

    // Pick the write-back value for the incoming instruction.
    always_comb begin
        src = wb_select(M_opcode);
        case (src)
            WB_SRC_MEM: sel_data = m_valM;
            WB_SRC_PC:  sel_data = M_default_pc;
            WB_SRC_ALU: sel_data = M_valE;
            default:    sel_data = '0;
        endcase
        sel_wen = (src != WB_SRC_NONE) && (M_rd != '0);
    end

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign w_allow_in = ~full & ~halted_q;
    assign enq        = m_to_w_valid & w_allow_in;
    // The reset cycle never writes the register file.
    assign retire     = ~empty & ~halted_q & ~rst & (rf_wr_ready | ~ctrl_q[head_q].wen);

    assign w_valid  = ~empty;
    assign W_commit = retire;
    assign rf_we    = retire & ctrl_q[head_q].wen;
    assign rf_waddr = rd_q[head_q];
    assign rf_wdata = data_q[head_q];
    assign halted   = halted_q;
    assign count    = count_q;

    // Pointer, occupancy and halt bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            if (enq) tail_q <= tail_q + PTR_W'(1);
            if (retire) begin
                head_q <= head_q + PTR_W'(1);
                if (ctrl_q[head_q].is_ebreak) halted_q <= 1'b1;
            end
            count_q <= count_q + CNT_W'(enq) - CNT_W'(retire);
        end
    end

    // Entry payload written at the tail; contents are don't-care until valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            ctrl_q[tail_q] <= '{wen: sel_wen, is_ebreak: (M_instr == XLEN'(EBREAK))};
            rd_q[tail_q]   <= M_rd;
            data_q[tail_q] <= sel_data;
        end
    end

    // Valid entries are the count_q slots starting at the head.
    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off           = PTR_W'(i) - head_q;
            valid_mask[i] = ({1'b0, off} < count_q);
            wen_mask[i]   = ctrl_q[i].wen;
        end
    end

    wb_fwd_match #(
        .XLEN (XLEN),
        .DEPTH(DEPTH),
        .RD_W (RD_W)
    ) u_fwd (
        .head    (head_q),
        .valid   (valid_mask),
        .wen     (wen_mask),
        .rd_arr  (rd_q),
        .data_arr(data_q),
        .fwd_rs  (fwd_rs),
        .fwd_hit (fwd_hit),
        .fwd_data(fwd_data)
    );

`ifdef WB_TRACE_EN
    logic [XLEN-1:0] cur_pc_q [DEPTH];
    logic [XLEN-1:0] instr_q  [DEPTH];
    logic [XLEN-1:0] pred_q   [DEPTH];
    logic [XLEN-1:0] predd_q  [DEPTH];

    // Trace fields travel with the entry and are shown only when it retires.
    always_ff @(posedge clk) begin
        if (enq) begin
            cur_pc_q[tail_q] <= M_cur_pc;
            instr_q[tail_q]  <= M_instr;
            pred_q[tail_q]   <= M_pred_pc;
            predd_q[tail_q]  <= M_predicted_pc;
        end
    end

    assign W_cur_pc       = retire ? cur_pc_q[head_q] : '0;
    assign W_instr        = retire ? instr_q[head_q]  : '0;
    assign W_pred_pc      = retire ? pred_q[head_q]   : '0;
    assign W_predicted_pc = retire ? predd_q[head_q]  : '0;
`else
    logic unused_trace;
    assign unused_trace   = ^{M_cur_pc, M_pred_pc, M_predicted_pc};
    assign W_cur_pc       = '0;
    assign W_instr        = '0;
    assign W_pred_pc      = '0;
    assign W_predicted_pc = '0;
`endif

endmodule
